// File: rtl/golay24_dec_types.sv
// Shared types for the Golay(24) decoder metric path: default LLR/codeword
// typedefs and the metric width function.
package golay24_dec_types;

  localparam int cN_DEF     = 24;
  localparam int cLLR_W_DEF = 4;

  typedef logic signed [cLLR_W_DEF-1:0] llr_t;
  typedef logic        [cN_DEF-1:0]     dat_t;

  // One guard bit so the most negative LLR negates cleanly, plus growth of the sum
  function automatic int metric_w(input int n, input int llr_w);
    return llr_w + 1 + $clog2(n);
  endfunction

endpackage

// File: rtl/golay24_dec_metric_tree.sv
// Registered binary adder tree: clog2(pN) levels, odd operands pass through
// a register so every leaf arrives at the root with the same latency.
module golay24_dec_metric_tree #(
  parameter int pN = 24,
  parameter int MW = 10
) (
  input  logic                   iclk,
  input  logic                   iclkena,
  input  logic [pN-1:0][MW-1:0]  iterm,
  output logic [MW-1:0]          osum
);

  localparam int D = $clog2(pN);

  function automatic int n_at(input int l);
    return (pN + (1 << l) - 1) >> l;
  endfunction

  logic [MW-1:0] node [1:D][pN];

  genvar l, j;
  generate
    for (l = 1; l <= D; l++) begin : g_lvl
      for (j = 0; j < n_at(l); j++) begin : g_node
        if (l == 1) begin : g_leaf
          if (2*j+1 < pN) begin : g_add
            always_ff @(posedge iclk) if (iclkena) node[l][j] <= iterm[2*j] + iterm[2*j+1];
          end else begin : g_pass
            always_ff @(posedge iclk) if (iclkena) node[l][j] <= iterm[2*j];
          end
        end else begin : g_inner
          if (2*j+1 < n_at(l-1)) begin : g_add
            always_ff @(posedge iclk) if (iclkena) node[l][j] <= node[l-1][2*j] + node[l-1][2*j+1];
          end else begin : g_pass
            always_ff @(posedge iclk) if (iclkena) node[l][j] <= node[l-1][2*j];
          end
        end
      end
    end
  endgenerate

  assign osum = node[D][0];

endmodule

// File: rtl/golay24_dec_metric_select.sv
// Picks the max-correlation candidate of each framed list of Golay(24) decodes.
// Define GOLAY24_DEC_METRIC_SELECT_CAND_OUT_EN to also stream every candidate metric.
module golay24_dec_metric_select
  import golay24_dec_types::*;
#(
  parameter int pN     = 24,
  parameter int pLLR_W = 4,
  parameter int pIDX_W = 6
) (
  input  logic                            iclk,
  input  logic                            ireset,
  input  logic                            iclkena,
  input  logic                            isop,
  input  logic                            ival,
  input  logic                            ieop,
  input  logic [pN-1:0]                   idat,
  input  logic                            ifailed,
  input  logic [pN-1:0][pLLR_W-1:0]       iLLR,
  output logic                            oval,
  output logic [pN-1:0]                   odat,
  output logic signed [metric_w(pN, pLLR_W)-1:0] ometric,
  output logic [pIDX_W-1:0]               oidx,
  output logic                            ofailed
`ifdef GOLAY24_DEC_METRIC_SELECT_CAND_OUT_EN
  ,
  output logic                            ocand_val,
  output logic signed [metric_w(pN, pLLR_W)-1:0] ocand_metric,
  output logic [pIDX_W-1:0]               ocand_idx,
  output logic                            ocand_failed
`endif
);

  localparam int MW = metric_w(pN, pLLR_W);
  localparam int D  = $clog2(pN);

  typedef logic signed [MW-1:0] metric_t;

  // dat carries the hard decision instead of the codeword for failed candidates
  typedef struct packed {
    logic              sop;
    logic              eop;
    logic              failed;
    logic [pIDX_W-1:0] idx;
    logic [pN-1:0]     dat;
  } side_t;

  logic                  accept;
  logic                  frame_open;
  logic [pIDX_W-1:0]     idx_cnt, cur_idx;
  logic [pN-1:0]         hd;
  logic [pN-1:0][MW-1:0] term_d, term_q;
  side_t                 side_in;
  side_t                 sb [D+1];
  logic [D:0]            vld;
  logic [MW-1:0]         tree_sum;
  metric_t               cand_metric;
  side_t                 cand;
  logic                  cand_val;

  logic                  have_best, nhave;
  metric_t               best_m, nm;
  logic [pIDX_W-1:0]     best_idx, nidx;
  logic [pN-1:0]         best_dat, ndat;

  always_comb begin
    accept  = ival && (isop || frame_open);
    cur_idx = isop ? '0 : idx_cnt;
    hd      = '0;
    term_d  = '0;
    for (int i = 0; i < pN; i++) begin
      hd[i]     = !iLLR[i][pLLR_W-1] && (|iLLR[i]);
      term_d[i] = {{(MW-pLLR_W){iLLR[i][pLLR_W-1]}}, iLLR[i]};
      if (!idat[i]) term_d[i] = -term_d[i];
    end
    side_in        = '0;
    side_in.sop    = isop;
    side_in.eop    = ieop;
    side_in.failed = ifailed;
    side_in.idx    = cur_idx;
    side_in.dat    = ifailed ? hd : idat;
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      frame_open <= 1'b0;
      idx_cnt    <= '0;
      vld        <= '0;
    end else if (iclkena) begin
      vld <= {vld[D-1:0], accept};
      if (accept) begin
        frame_open <= !ieop;
        idx_cnt    <= (cur_idx == '1) ? cur_idx : cur_idx + pIDX_W'(1);
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (iclkena) begin
      term_q <= term_d;
      sb[0]  <= side_in;
      for (int k = 1; k <= D; k++) sb[k] <= sb[k-1];
    end
  end

  golay24_dec_metric_tree #(
    .pN (pN),
    .MW (MW)
  ) u_tree (
    .iclk    (iclk),
    .iclkena (iclkena),
    .iterm   (term_q),
    .osum    (tree_sum)
  );

  assign cand_metric = tree_sum;
  assign cand        = sb[D];
  assign cand_val    = vld[D];

  // Strictly-greater replace keeps the lowest index on ties
  always_comb begin
    nhave = have_best;
    nm    = best_m;
    nidx  = best_idx;
    ndat  = best_dat;
    if (cand_val) begin
      if (cand.sop) begin
        nhave = 1'b0;
        if (cand.failed) ndat = cand.dat;
      end
      if (!cand.failed && (!nhave || cand_metric > nm)) begin
        nhave = 1'b1;
        nm    = cand_metric;
        nidx  = cand.idx;
        ndat  = cand.dat;
      end
    end
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      have_best <= 1'b0;
      best_m    <= '0;
      best_idx  <= '0;
      best_dat  <= '0;
      oval      <= 1'b0;
      odat      <= '0;
      ometric   <= '0;
      oidx      <= '0;
      ofailed   <= 1'b0;
    end else if (iclkena) begin
      have_best <= nhave;
      best_m    <= nm;
      best_idx  <= nidx;
      best_dat  <= ndat;
      oval      <= cand_val && cand.eop;
      if (cand_val && cand.eop) begin
        ofailed <= !nhave;
        ometric <= nhave ? nm : '0;
        oidx    <= nhave ? nidx : '0;
        odat    <= ndat;
      end
    end
  end

`ifdef GOLAY24_DEC_METRIC_SELECT_CAND_OUT_EN
  assign ocand_val    = cand_val;
  assign ocand_metric = cand_metric;
  assign ocand_idx    = cand.idx;
  assign ocand_failed = cand.failed;
`endif

endmodule
